// File: rtl/ddr_burst_tx.sv
// ddr_burst_tx: N-lane DDR transmit block. Words (rising half d0, falling half d1) enter a
// FIFO over a valid/ready stream and are replayed as bursts on a WIDTH-bit DDR bus, with a
// registered output enable for pad tristate control.
module ddr_burst_tx #(
   parameter int unsigned      WIDTH       = 4,
   parameter int unsigned      DEPTH       = 8,
   parameter int unsigned      START_LEVEL = 2,
   parameter int unsigned      OE_HOLD     = 2,
   parameter logic [WIDTH-1:0] IDLE_VAL    = '0
) (
   input  logic                   SCLK,
   input  logic                   RST_N,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_d0,
   input  logic [WIDTH-1:0]       in_d1,
   input  logic                   in_last,
   output logic [WIDTH-1:0]       Q,
   output logic                   OE,
   output logic [$clog2(DEPTH):0] level,
   output logic [7:0]             underrun_cnt,
   output logic                   busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] DepthL = CW'(DEPTH);
   localparam logic [CW-1:0] StartL = CW'(START_LEVEL);
   localparam logic [CW-1:0] CntOne = CW'(1);
   localparam logic [AW-1:0] PtrOne = AW'(1);
   localparam logic [3:0]    HoldL  = 4'(OE_HOLD);

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] d1;
      logic [WIDTH-1:0] d0;
   } word_t;

   typedef enum logic [1:0] {StIdle, StActive, StHold} state_e;

   word_t           mem_q [DEPTH];
   word_t           rd_word;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   state_e          state_q, state_d;
   logic [3:0]      hold_q, hold_d;
   logic [7:0]      under_q, under_d;
   logic            oe_q, oe_d;
   logic [WIDTH-1:0] d0_q, d0_d;
   logic [WIDTH-1:0] d1_q, d1_d;
   logic [WIDTH-1:0] d1_n_q;
   logic            push, pop;

   // in_ready depends only on the registered level, never on this cycle's pop
   assign in_ready = (cnt_q < DepthL);
   assign push     = in_valid && in_ready;
   assign rd_word  = mem_q[rd_ptr_q];

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop) begin
         cnt_d = cnt_q + CntOne;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   // Burst FSM: pop decision, OE, hold counter and underrun counter
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      under_d = under_q;
      oe_d    = oe_q;
      pop     = 1'b0;

      unique case (state_q)
         StIdle: begin
            oe_d = 1'b0;
            // Arm here; the first pop follows on the next edge so OE rises with d0
            if (cnt_q >= StartL) state_d = StActive;
         end
         StActive: pop = (cnt_q != '0);
         StHold:   pop = (cnt_q >= StartL);
         default:  state_d = StIdle;
      endcase

      if (pop) begin
         oe_d   = 1'b1;
         hold_d = '0;
         if (rd_word.last) begin
            state_d = StHold;
         end else begin
            state_d = StActive;
            // Nothing poppable next edge: the burst was starved before in_last
            if (cnt_q == CntOne && !push && under_q != 8'hFF) under_d = under_q + 8'd1;
         end
      end else if (state_q == StActive) begin
         // Starved burst: this cycle is already the first idle one after the last word
         if (HoldL == 4'd0) begin
            state_d = StIdle;
            oe_d    = 1'b0;
         end else begin
            state_d = StHold;
            hold_d  = 4'd1;
            oe_d    = 1'b1;
         end
      end else if (state_q == StHold) begin
         if (hold_q >= HoldL) begin
            state_d = StIdle;
            oe_d    = 1'b0;
         end else begin
            hold_d = hold_q + 4'd1;
            oe_d   = 1'b1;
         end
      end
   end

   // Output halves for the coming cycle; IDLE_VAL in both phases when nothing is popped
   always_comb begin
      d0_d = IDLE_VAL;
      d1_d = IDLE_VAL;
      if (pop) begin
         d0_d = rd_word.d0;
         d1_d = rd_word.d1;
      end
   end

   // FIFO storage; pointers carry the flush, so the array needs no reset
   always_ff @(posedge SCLK) begin
      if (push) mem_q[wr_ptr_q] <= {in_last, in_d1, in_d0};
   end

   // Posedge state
   always_ff @(posedge SCLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= StIdle;
         hold_q   <= '0;
         under_q  <= '0;
         oe_q     <= 1'b0;
         d0_q     <= IDLE_VAL;
         d1_q     <= IDLE_VAL;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         under_q  <= under_d;
         oe_q     <= oe_d;
         d0_q     <= d0_d;
         d1_q     <= d1_d;
      end
   end

   // Negedge stage: moves the staged d1 into the low phase
   always_ff @(negedge SCLK or negedge RST_N) begin
      if (!RST_N) begin
         d1_n_q <= IDLE_VAL;
      end else begin
         d1_n_q <= d1_q;
      end
   end

   // DDR mux: d0 while SCLK is high, d1 while it is low
   assign Q            = SCLK ? d0_q : d1_n_q;
   assign OE           = oe_q;
   assign level        = cnt_q;
   assign underrun_cnt = under_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_ddr_burst_tx.sv
// Directed bench for ddr_burst_tx: default build (dut_a) and a START_LEVEL=8 build (dut_b).
module tb_ddr_burst_tx;

   logic       SCLK = 1'b0;
   logic       RST_N = 1'b0;

   logic       va, ra, la, oea, bsa;
   logic [3:0] d0a, d1a, qa, lva;
   logic [7:0] uca;

   logic       vb, rb, lb, oeb, bsb;
   logic [3:0] d0b, d1b, qb, lvb;
   logic [7:0] ucb;

   int n_cmp = 0;
   int n_err = 0;

   always #5 SCLK = ~SCLK;

   ddr_burst_tx dut_a (
      .SCLK(SCLK), .RST_N(RST_N), .in_valid(va), .in_ready(ra), .in_d0(d0a), .in_d1(d1a),
      .in_last(la), .Q(qa), .OE(oea), .level(lva), .underrun_cnt(uca), .busy(bsa)
   );

   ddr_burst_tx #(.START_LEVEL(8)) dut_b (
      .SCLK(SCLK), .RST_N(RST_N), .in_valid(vb), .in_ready(rb), .in_d0(d0b), .in_d1(d1b),
      .in_last(lb), .Q(qb), .OE(oeb), .level(lvb), .underrun_cnt(ucb), .busy(bsb)
   );

   task automatic tick();
      @(posedge SCLK);
      #1;
   endtask

   task automatic push_a(input logic [3:0] x0, input logic [3:0] x1, input logic lst);
      va = 1'b1; d0a = x0; d1a = x1; la = lst;
      tick();
      va = 1'b0; la = 1'b0;
   endtask

   task automatic push_b(input logic [3:0] x0, input logic [3:0] x1, input logic lst);
      vb = 1'b1; d0b = x0; d1b = x1; lb = lst;
      tick();
      vb = 1'b0; lb = 1'b0;
   endtask

   task automatic wait_oe_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (oea) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) tick();
      RST_N = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL reset_q_hi: got %h want 0", qa); end
         n_cmp++; if (oea !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", oea); end
         n_cmp++; if (bsa !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bsa); end
         n_cmp++; if (lva !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", lva); end
         @(negedge SCLK); #1;
         n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL reset_q_lo: got %h want 0", qa); end
      end
      n_cmp++; if (uca !== 8'd0) begin n_err++; $display("FAIL reset_underrun: got %0d want 0", uca); end
      n_cmp++; if (ra !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ra); end
   endtask

   task automatic test_burst3();
      logic [3:0] e0 [3];
      logic [3:0] e1 [3];
      bit ok;
      int hc;
      e0 = '{4'd1, 4'd3, 4'd5};
      e1 = '{4'd2, 4'd4, 4'd6};
      push_a(4'd1, 4'd2, 1'b0);
      push_a(4'd3, 4'd4, 1'b0);
      push_a(4'd5, 4'd6, 1'b1);
      wait_oe_a(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL burst3_oe_rise: got %b want 1", oea); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (qa !== e0[i]) begin n_err++; $display("FAIL burst3_d0[%0d]: got %h want %h", i, qa, e0[i]); end
         n_cmp++; if (oea !== 1'b1) begin n_err++; $display("FAIL burst3_oe[%0d]: got %b want 1", i, oea); end
         @(negedge SCLK); #1;
         n_cmp++; if (qa !== e1[i]) begin n_err++; $display("FAIL burst3_d1[%0d]: got %h want %h", i, qa, e1[i]); end
         tick();
      end
      hc = 0;
      for (int c = 0; c < 20; c++) begin
         if (!oea) break;
         n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL burst3_hold_q: got %h want 0", qa); end
         hc++;
         tick();
      end
      n_cmp++; if (hc != 2) begin n_err++; $display("FAIL burst3_hold_len: got %0d want 2", hc); end
      n_cmp++; if (uca !== 8'd0) begin n_err++; $display("FAIL burst3_underrun: got %0d want 0", uca); end
      n_cmp++; if (bsa !== 1'b0) begin n_err++; $display("FAIL burst3_busy: got %b want 0", bsa); end
      n_cmp++; if (lva !== 4'd0) begin n_err++; $display("FAIL burst3_level: got %0d want 0", lva); end
   endtask

   task automatic test_underrun();
      logic [3:0] e0 [2];
      logic [3:0] e1 [2];
      bit ok;
      int hc;
      e0 = '{4'd7, 4'd9};
      e1 = '{4'd8, 4'd10};
      push_a(4'd7, 4'd8, 1'b0);
      push_a(4'd9, 4'd10, 1'b0);
      wait_oe_a(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL underrun_oe_rise: got %b want 1", oea); end
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (qa !== e0[i]) begin n_err++; $display("FAIL underrun_d0[%0d]: got %h want %h", i, qa, e0[i]); end
         @(negedge SCLK); #1;
         n_cmp++; if (qa !== e1[i]) begin n_err++; $display("FAIL underrun_d1[%0d]: got %h want %h", i, qa, e1[i]); end
         tick();
      end
      hc = 0;
      for (int c = 0; c < 20; c++) begin
         if (!oea) break;
         n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL underrun_idle_q: got %h want 0", qa); end
         hc++;
         tick();
      end
      n_cmp++; if (hc != 2) begin n_err++; $display("FAIL underrun_idle_len: got %0d want 2", hc); end
      n_cmp++; if (uca !== 8'd1) begin n_err++; $display("FAIL underrun_cnt: got %0d want 1", uca); end
      n_cmp++; if (bsa !== 1'b0) begin n_err++; $display("FAIL underrun_busy: got %b want 0", bsa); end
   endtask

   task automatic test_fill();
      bit ok;
      for (int i = 0; i < 8; i++) push_b(4'(i), 4'(15 - i), (i == 7));
      n_cmp++; if (rb !== 1'b0) begin n_err++; $display("FAIL fill_ready_full: got %b want 0", rb); end
      n_cmp++; if (lvb !== 4'd8) begin n_err++; $display("FAIL fill_level_full: got %0d want 8", lvb); end
      // Must be dropped: the FIFO is full at this edge
      push_b(4'hF, 4'hF, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (oeb) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL fill_oe_rise: got %b want 1", oeb); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (qb !== 4'(i)) begin n_err++; $display("FAIL fill_d0[%0d]: got %h want %h", i, qb, 4'(i)); end
         @(negedge SCLK); #1;
         n_cmp++; if (qb !== 4'(15 - i)) begin n_err++; $display("FAIL fill_d1[%0d]: got %h want %h", i, qb, 4'(15 - i)); end
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         if (!oeb) break;
         tick();
      end
      n_cmp++; if (oeb !== 1'b0) begin n_err++; $display("FAIL fill_oe_fall: got %b want 0", oeb); end
      n_cmp++; if (lvb !== 4'd0) begin n_err++; $display("FAIL fill_level_after: got %0d want 0", lvb); end
      n_cmp++; if (rb !== 1'b1) begin n_err++; $display("FAIL fill_ready_after: got %b want 1", rb); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] e0 [4];
      logic [3:0] e1 [4];
      int idx;
      int gap;
      bit started;
      e0 = '{4'h1, 4'h3, 4'hA, 4'hC};
      e1 = '{4'h2, 4'h4, 4'hB, 4'hD};
      idx = 0;
      gap = 0;
      started = 1'b0;
      fork
         begin
            push_a(4'h1, 4'h2, 1'b0);
            push_a(4'h3, 4'h4, 1'b1);
            repeat (2) tick();
            push_a(4'hA, 4'hB, 1'b0);
            push_a(4'hC, 4'hD, 1'b1);
         end
         begin
            for (int c = 0; c < 40 && idx < 4; c++) begin
               tick();
               if (!started && oea) started = 1'b1;
               if (started) begin
                  n_cmp++; if (oea !== 1'b1) begin n_err++; $display("FAIL b2b_oe_gap: got %b want 1 (word %0d)", oea, idx); end
                  if (qa === 4'd0) begin
                     gap++;
                  end else begin
                     n_cmp++; if (qa !== e0[idx]) begin n_err++; $display("FAIL b2b_d0[%0d]: got %h want %h", idx, qa, e0[idx]); end
                     @(negedge SCLK); #1;
                     n_cmp++; if (qa !== e1[idx]) begin n_err++; $display("FAIL b2b_d1[%0d]: got %h want %h", idx, qa, e1[idx]); end
                     idx++;
                  end
               end
            end
         end
      join
      n_cmp++; if (idx != 4) begin n_err++; $display("FAIL b2b_words: got %0d want 4", idx); end
      n_cmp++; if (gap > 2) begin n_err++; $display("FAIL b2b_idle_gap: got %0d want <=2", gap); end
      for (int c = 0; c < 20; c++) begin
         if (!oea) break;
         tick();
      end
      n_cmp++; if (oea !== 1'b0) begin n_err++; $display("FAIL b2b_oe_fall: got %b want 0", oea); end
      n_cmp++; if (lva !== 4'd0) begin n_err++; $display("FAIL b2b_level: got %0d want 0", lva); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      push_a(4'h1, 4'h2, 1'b0);
      push_a(4'h3, 4'h4, 1'b0);
      push_a(4'h5, 4'h6, 1'b1);
      wait_oe_a(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_oe_rise: got %b want 1", oea); end
      tick();
      @(negedge SCLK);
      RST_N = 1'b0;
      #1;
      n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL rstmid_q: got %h want 0", qa); end
      n_cmp++; if (oea !== 1'b0) begin n_err++; $display("FAIL rstmid_oe: got %b want 0", oea); end
      n_cmp++; if (lva !== 4'd0) begin n_err++; $display("FAIL rstmid_level: got %0d want 0", lva); end
      repeat (2) tick();
      RST_N = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL rstmid_after_q_hi: got %h want 0", qa); end
         n_cmp++; if (oea !== 1'b0) begin n_err++; $display("FAIL rstmid_after_oe: got %b want 0", oea); end
         n_cmp++; if (lva !== 4'd0) begin n_err++; $display("FAIL rstmid_after_level: got %0d want 0", lva); end
         @(negedge SCLK); #1;
         n_cmp++; if (qa !== 4'd0) begin n_err++; $display("FAIL rstmid_after_q_lo: got %h want 0", qa); end
      end
      n_cmp++; if (uca !== 8'd0) begin n_err++; $display("FAIL rstmid_underrun: got %0d want 0", uca); end
   endtask

   initial begin
      va = 1'b0; la = 1'b0; d0a = '0; d1a = '0;
      vb = 1'b0; lb = 1'b0; d0b = '0; d1b = '0;
      test_reset();
      test_burst3();
      test_underrun();
      test_fill();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
